mux_sel_stream: RTL and testbench

- Parametrised N-channel, WIDTH-bit selector; successor to the fixed 16-bit mux tree.
- Adds a registered output stage with valid/ready handshake and two selection modes:
  - direct: external select.
  - round-robin: automatic fair scan over valid channels.
- Out-of-range selects produce no transfer and a flagged error instead of silently driving zero.
- Sits between multiple producer lanes and a single downstream consumer (ALU operand path, display/readout).

---
 rtl/mux_sel_stream.sv | 156 +++++++++++++++
 tb/tb_mux_sel_stream.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/mux_sel_stream.sv
// mux_sel_stream: NCH-channel WIDTH-bit selector with a registered
// valid/ready output stage. Supports direct (external sel) and round-robin
// channel selection; out-of-range direct selects are flagged on sel_err.
module mux_sel_stream #(
  parameter int WIDTH = 16,
  parameter int NCH   = 12,
  parameter int SELW  = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NCH*WIDTH-1:0]   in_data,
  input  logic [NCH-1:0]         in_valid,
  output logic [NCH-1:0]         in_ready,
  input  logic                   mode,
  input  logic [SELW-1:0]        sel,
  output logic [WIDTH-1:0]       out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [SELW-1:0]        out_ch,
  output logic                   sel_err
);

  // Channel count and last index expressed at select width (+1 bit so that
  // NCH == 2**SELW still fits for range comparisons).
  localparam logic [SELW:0]   NCH_W   = (SELW+1)'(NCH);
  localparam logic [SELW-1:0] LAST_CH = SELW'(NCH-1);
  localparam logic [SELW-1:0] ONE_SEL = {{(SELW-1){1'b0}}, 1'b1};

  // Next round-robin start position: one past the granted channel, wrapping.
  function automatic logic [SELW-1:0] wrap_inc(input logic [SELW-1:0] ch);
    logic [SELW-1:0] nxt;
    if (ch == LAST_CH) begin
      nxt = {SELW{1'b0}};
    end else begin
      nxt = ch + ONE_SEL;
    end
    return nxt;
  endfunction

  logic [WIDTH-1:0] r_out_data;
  logic             r_out_valid;
  logic [SELW-1:0]  r_out_ch;
  logic             r_sel_err;
  logic [SELW-1:0]  r_rr_ptr;

  logic             w_load_en;
  logic [SELW-1:0]  w_gnt;
  logic             w_gnt_vld;
  logic             w_xfer;
  logic [WIDTH-1:0] w_gnt_data;
  logic             w_sel_oor;

  assign w_load_en = !r_out_valid || out_ready;
  assign w_xfer    = w_gnt_vld && w_load_en;
  assign w_sel_oor = ({1'b0, sel} >= NCH_W);

  // Grant selection: direct match on sel, or first valid channel scanning
  // upward from the round-robin pointer with wrap at NCH.
  always_comb begin : p_grant
    logic [SELW:0]   v_idx;
    logic [SELW-1:0] v_gnt;
    logic            v_vld;
    v_idx = {(SELW+1){1'b0}};
    v_gnt = {SELW{1'b0}};
    v_vld = 1'b0;
    if (mode == 1'b0) begin
      // Only in-range indices can match, so sel >= NCH never grants.
      for (int k = 0; k < NCH; k++) begin
        if (sel == SELW'(k) && in_valid[k]) begin
          v_gnt = SELW'(k);
          v_vld = 1'b1;
        end else begin
          v_vld = v_vld;
        end
      end
    end else begin
      for (int i = 0; i < NCH; i++) begin
        // r_rr_ptr < NCH and i < NCH, so a single subtraction wraps.
        v_idx = {1'b0, r_rr_ptr} + (SELW+1)'(i);
        if (v_idx >= NCH_W) begin
          v_idx = v_idx - NCH_W;
        end else begin
          v_idx = v_idx;
        end
        for (int k = 0; k < NCH; k++) begin
          if (!v_vld && in_valid[k] && v_idx == (SELW+1)'(k)) begin
            v_gnt = SELW'(k);
            v_vld = 1'b1;
          end else begin
            v_vld = v_vld;
          end
        end
      end
    end
    w_gnt     = v_gnt;
    w_gnt_vld = v_vld;
  end

  // Data mux for the granted channel.
  always_comb begin
    w_gnt_data = {WIDTH{1'b0}};
    for (int k = 0; k < NCH; k++) begin
      if (w_gnt == SELW'(k)) begin
        w_gnt_data = in_data[k*WIDTH +: WIDTH];
      end else begin
        w_gnt_data = w_gnt_data;
      end
    end
  end

  // Upstream accept: one-hot on the granted channel when the output
  // register can take a word; forced low during reset.
  always_comb begin
    in_ready = {NCH{1'b0}};
    if (rst) begin
      in_ready = {NCH{1'b0}};
    end else begin
      for (int k = 0; k < NCH; k++) begin
        in_ready[k] = w_xfer && (w_gnt == SELW'(k));
      end
    end
  end

  // Output register, round-robin pointer and select-error flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_data  <= {WIDTH{1'b0}};
      r_out_valid <= 1'b0;
      r_out_ch    <= {SELW{1'b0}};
      r_sel_err   <= 1'b0;
      r_rr_ptr    <= {SELW{1'b0}};
    end else begin
      r_sel_err <= (mode == 1'b0) && w_sel_oor;
      if (w_xfer) begin
        r_out_data  <= w_gnt_data;
        r_out_ch    <= w_gnt;
        r_out_valid <= 1'b1;
        if (mode == 1'b1) begin
          r_rr_ptr <= wrap_inc(w_gnt);
        end else begin
          r_rr_ptr <= r_rr_ptr;
        end
      end else if (w_load_en) begin
        r_out_valid <= 1'b0;
      end else begin
        r_out_valid <= r_out_valid;
      end
    end
  end

  assign out_data  = r_out_data;
  assign out_valid = r_out_valid;
  assign out_ch    = r_out_ch;
  assign sel_err   = r_sel_err;

endmodule

// File: tb/tb_mux_sel_stream.sv
// Directed self-checking bench for mux_sel_stream (WIDTH=16, NCH=12).
module tb_mux_sel_stream;

  logic         clk;
  logic         rst;
  logic [191:0] in_data;
  logic [11:0]  in_valid;
  logic [11:0]  in_ready;
  logic         mode;
  logic [3:0]   sel;
  logic [15:0]  out_data;
  logic         out_valid;
  logic         out_ready;
  logic [3:0]   out_ch;
  logic         sel_err;

  logic [15:0]  ch_data [12];
  int           n_chk;
  int           n_fail;

  mux_sel_stream #(.WIDTH(16), .NCH(12), .SELW(4)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .mode(mode), .sel(sel), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_ch(out_ch),
    .sel_err(sel_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pack per-channel data into the flattened bus.
  always_comb begin
    in_data = '0;
    for (int k = 0; k < 12; k++) in_data[k*16 +: 16] = ch_data[k];
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; mode = 1'b0; sel = 4'd0; in_valid = 12'hFFF; out_ready = 1'b1;
    for (int k = 0; k < 12; k++) ch_data[k] = 16'hA000 + 16'(k);
    step(); step();
    n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b exp 0", out_valid); end
    n_chk++; if (out_data !== 16'h0000) begin n_fail++; $display("FAIL reset_data: got %h exp 0000", out_data); end
    n_chk++; if (out_ch !== 4'd0) begin n_fail++; $display("FAIL reset_ch: got %0d exp 0", out_ch); end
    n_chk++; if (sel_err !== 1'b0) begin n_fail++; $display("FAIL reset_selerr: got %b exp 0", sel_err); end
    n_chk++; if (in_ready !== 12'h000) begin n_fail++; $display("FAIL reset_inready: got %h exp 000", in_ready); end
    in_valid = 12'h000;
    rst = 1'b0;
    step();
  endtask

  task automatic test_direct_bp();
    mode = 1'b0; sel = 4'd5; in_valid = 12'h020; out_ready = 1'b0; ch_data[5] = 16'hBEEF;
    #1;
    n_chk++; if (in_ready !== 12'h020) begin n_fail++; $display("FAIL dir_ready0: got %h exp 020", in_ready); end
    step();
    n_chk++; if (out_data !== 16'hBEEF) begin n_fail++; $display("FAIL dir_data: got %h exp BEEF", out_data); end
    n_chk++; if (out_ch !== 4'd5) begin n_fail++; $display("FAIL dir_ch: got %0d exp 5", out_ch); end
    n_chk++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL dir_valid: got %b exp 1", out_valid); end
    ch_data[5] = 16'h1234;
    #1;
    n_chk++; if (in_ready !== 12'h000) begin n_fail++; $display("FAIL dir_bp_ready: got %h exp 000", in_ready); end
    step();
    n_chk++; if (out_data !== 16'hBEEF) begin n_fail++; $display("FAIL dir_hold_data: got %h exp BEEF", out_data); end
    n_chk++; if (in_ready !== 12'h000) begin n_fail++; $display("FAIL dir_bp_ready2: got %h exp 000", in_ready); end
    out_ready = 1'b1;
    #1;
    n_chk++; if (in_ready !== 12'h020) begin n_fail++; $display("FAIL dir_ready_rise: got %h exp 020", in_ready); end
    step();
    n_chk++; if (out_data !== 16'h1234) begin n_fail++; $display("FAIL dir_b2b_data: got %h exp 1234", out_data); end
    n_chk++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL dir_b2b_valid: got %b exp 1", out_valid); end
    in_valid = 12'h000;
    step();
    n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL dir_drain_valid: got %b exp 0", out_valid); end
    n_chk++; if (out_data !== 16'h1234) begin n_fail++; $display("FAIL dir_drain_hold: got %h exp 1234", out_data); end
    n_chk++; if (out_ch !== 4'd5) begin n_fail++; $display("FAIL dir_drain_ch: got %0d exp 5", out_ch); end
    ch_data[5] = 16'hA005;
  endtask

  task automatic test_out_of_range();
    mode = 1'b0; sel = 4'd4; in_valid = 12'hFFF; out_ready = 1'b1;
    step();
    n_chk++; if (out_ch !== 4'd4) begin n_fail++; $display("FAIL oor_pre_ch: got %0d exp 4", out_ch); end
    n_chk++; if (sel_err !== 1'b0) begin n_fail++; $display("FAIL oor_pre_err: got %b exp 0", sel_err); end
    sel = 4'd12;
    #1;
    n_chk++; if (in_ready !== 12'h000) begin n_fail++; $display("FAIL oor12_ready: got %h exp 000", in_ready); end
    step();
    n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL oor12_valid: got %b exp 0", out_valid); end
    n_chk++; if (sel_err !== 1'b1) begin n_fail++; $display("FAIL oor12_err: got %b exp 1", sel_err); end
    n_chk++; if (out_ch !== 4'd4) begin n_fail++; $display("FAIL oor12_ch_hold: got %0d exp 4", out_ch); end
    n_chk++; if (out_data !== 16'hA004) begin n_fail++; $display("FAIL oor12_data_hold: got %h exp A004", out_data); end
    sel = 4'd15;
    #1;
    n_chk++; if (in_ready !== 12'h000) begin n_fail++; $display("FAIL oor15_ready: got %h exp 000", in_ready); end
    step();
    n_chk++; if (sel_err !== 1'b1) begin n_fail++; $display("FAIL oor15_err: got %b exp 1", sel_err); end
    n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL oor15_valid: got %b exp 0", out_valid); end
    sel = 4'd11;
    #1;
    n_chk++; if (in_ready !== 12'h800) begin n_fail++; $display("FAIL sel11_ready: got %h exp 800", in_ready); end
    step();
    n_chk++; if (sel_err !== 1'b0) begin n_fail++; $display("FAIL sel11_err: got %b exp 0", sel_err); end
    n_chk++; if (out_ch !== 4'd11) begin n_fail++; $display("FAIL sel11_ch: got %0d exp 11", out_ch); end
    n_chk++; if (out_data !== 16'hA00B) begin n_fail++; $display("FAIL sel11_data: got %h exp A00B", out_data); end
    n_chk++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL sel11_valid: got %b exp 1", out_valid); end
  endtask

  task automatic test_rr_fair();
    int cnt [12];
    logic [3:0] exp_ch;
    for (int k = 0; k < 12; k++) cnt[k] = 0;
    mode = 1'b1; in_valid = 12'hFFF; out_ready = 1'b1;
    for (int i = 0; i < 24; i++) begin
      step();
      exp_ch = 4'(i % 12);
      n_chk++; if (out_ch !== exp_ch || out_valid !== 1'b1) begin n_fail++; $display("FAIL rr_seq[%0d]: got ch %0d v %b exp ch %0d v 1", i, out_ch, out_valid, exp_ch); end
      n_chk++; if (out_data !== 16'hA000 + 16'(exp_ch)) begin n_fail++; $display("FAIL rr_data[%0d]: got %h exp %h", i, out_data, 16'hA000 + 16'(exp_ch)); end
      if (out_ch < 4'd12) cnt[out_ch] = cnt[out_ch] + 1;
    end
    for (int k = 0; k < 12; k++) begin
      n_chk++; if (cnt[k] !== 2) begin n_fail++; $display("FAIL rr_count[%0d]: got %0d exp 2", k, cnt[k]); end
    end
    n_chk++; if (sel_err !== 1'b0) begin n_fail++; $display("FAIL rr_selerr: got %b exp 0", sel_err); end
  endtask

  task automatic test_rr_skip_wrap();
    logic [3:0] exp_seq [4];
    exp_seq[0] = 4'd0; exp_seq[1] = 4'd3; exp_seq[2] = 4'd0; exp_seq[3] = 4'd3;
    mode = 1'b1; out_ready = 1'b1; in_valid = 12'h200;
    step();
    n_chk++; if (out_ch !== 4'd9) begin n_fail++; $display("FAIL skip_setup_ch: got %0d exp 9", out_ch); end
    in_valid = 12'h009;
    for (int i = 0; i < 4; i++) begin
      step();
      n_chk++; if (out_ch !== exp_seq[i]) begin n_fail++; $display("FAIL skip_seq[%0d]: got %0d exp %0d", i, out_ch, exp_seq[i]); end
    end
    in_valid = 12'h018;
    step();
    n_chk++; if (out_ch !== 4'd4) begin n_fail++; $display("FAIL skip_ptr4: got %0d exp 4", out_ch); end
  endtask

  task automatic test_mode_switch();
    mode = 1'b1; out_ready = 1'b1; in_valid = 12'h040;
    step();
    n_chk++; if (out_ch !== 4'd6) begin n_fail++; $display("FAIL sw_rr6: got %0d exp 6", out_ch); end
    mode = 1'b0; sel = 4'd2; in_valid = 12'hFFF;
    for (int i = 0; i < 3; i++) begin
      step();
      n_chk++; if (out_ch !== 4'd2) begin n_fail++; $display("FAIL sw_dir[%0d]: got %0d exp 2", i, out_ch); end
    end
    mode = 1'b1;
    step();
    n_chk++; if (out_ch !== 4'd7) begin n_fail++; $display("FAIL sw_rr_resume: got %0d exp 7", out_ch); end
  endtask

  task automatic test_reset_mid();
    mode = 1'b0; sel = 4'd3; in_valid = 12'hFFF; out_ready = 1'b1;
    step();
    sel = 4'd12; out_ready = 1'b0;
    step();
    n_chk++; if (out_valid !== 1'b1 || sel_err !== 1'b1 || out_ch !== 4'd3) begin n_fail++; $display("FAIL rmid_pre: got v %b err %b ch %0d exp v 1 err 1 ch 3", out_valid, sel_err, out_ch); end
    #2;
    rst = 1'b1;
    #1;
    n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_valid: got %b exp 0", out_valid); end
    n_chk++; if (out_data !== 16'h0000) begin n_fail++; $display("FAIL rmid_data: got %h exp 0000", out_data); end
    n_chk++; if (out_ch !== 4'd0) begin n_fail++; $display("FAIL rmid_ch: got %0d exp 0", out_ch); end
    n_chk++; if (sel_err !== 1'b0) begin n_fail++; $display("FAIL rmid_err: got %b exp 0", sel_err); end
    sel = 4'd3; out_ready = 1'b1;
    #1;
    n_chk++; if (in_ready !== 12'h000) begin n_fail++; $display("FAIL rmid_ready: got %h exp 000", in_ready); end
    step();
    rst = 1'b0;
    step();
    n_chk++; if (out_ch !== 4'd3 || out_valid !== 1'b1) begin n_fail++; $display("FAIL rmid_resume: got ch %0d v %b exp ch 3 v 1", out_ch, out_valid); end
  endtask

  initial begin
    n_chk = 0;
    n_fail = 0;
    test_reset();
    test_direct_bp();
    test_out_of_range();
    test_rr_fair();
    test_rr_skip_wrap();
    test_mode_switch();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
